// File: rtl/audio_gain.sv
// Two-stage signed sample scaler with debounced up/down volume buttons (gain = code/8).
// Define AUDIO_GAIN_SOFT_RAMP_EN to step the applied gain toward the target once per sample.
module audio_gain #(
  parameter int         DW              = 24,
  parameter int         DEBOUNCE_CYCLES = 250000,
  parameter logic [3:0] RESET_GAIN      = 4'd8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_sample,
  input  logic                 btn_up,
  input  logic                 btn_dn,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_sample,
  output logic [3:0]           gain_code
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic signed [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

  // Index 0 is the up button, index 1 the down button.
  logic [1:0]    raw, sync1, sync2, level, level_q, rise;
  logic [CW-1:0] cnt [2];
  logic [3:0]    target;

  assign raw  = {btn_dn, btn_up};
  assign rise = level & ~level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_q <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      // A level is accepted only after it has disagreed for a full unbroken window.
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]   <= '0;
          level[i] <= ~level[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target <= RESET_GAIN;
    end else begin
      case (rise)
        2'b01:   if (target != 4'd15) target <= target + 4'd1;
        2'b10:   if (target != 4'd0)  target <= target - 4'd1;
        default: target <= target;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gain_code <= RESET_GAIN;
    end else begin
`ifdef AUDIO_GAIN_SOFT_RAMP_EN
      if (in_valid) begin
        if (gain_code < target)      gain_code <= gain_code + 4'd1;
        else if (gain_code > target) gain_code <= gain_code - 4'd1;
      end
`else
      gain_code <= target;
`endif
    end
  end

  logic signed [DW+4:0] sample_ext, gain_ext, prod, shifted;
  logic signed [DW-1:0] sat_sample;
  logic                 v1, fits;

  assign sample_ext = (DW+5)'(in_sample);
  assign gain_ext   = (DW+5)'($signed({1'b0, gain_code}));

  always_comb begin
    shifted    = prod >>> 3;
    fits       = (&shifted[DW+4:DW-1]) | ~(|shifted[DW+4:DW-1]);
    sat_sample = shifted[DW-1:0];
    if (!fits) sat_sample = shifted[DW+4] ? SMIN : SMAX;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1         <= 1'b0;
      prod       <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
    end else begin
      v1        <= in_valid;
      out_valid <= v1;
      if (in_valid) prod <= sample_ext * gain_ext;
      if (v1) out_sample <= sat_sample;
    end
  end

endmodule

// File: tb/tb_audio_gain.sv
// Self-checking bench for audio_gain: vector table through a timed scoreboard plus button,
// saturation, soft-ramp and reset-in-flight sequences.
module tb_audio_gain;

  localparam int DW  = 24;
  localparam int DEB = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic signed [DW-1:0] in_sample;
  logic                 btn_up, btn_dn;
  logic                 out_valid;
  logic signed [DW-1:0] out_sample;
  logic [3:0]           gain_code;

  audio_gain #(.DW(DW), .DEBOUNCE_CYCLES(DEB), .RESET_GAIN(4'd8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sample(in_sample),
    .btn_up(btn_up), .btn_dn(btn_dn), .out_valid(out_valid),
    .out_sample(out_sample), .gain_code(gain_code)
  );

  always #5 clk = ~clk;

  typedef struct { int gain; int sample; int exp; } vec_t;
  typedef struct { int data; int due; } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;
  int   exp_gain;
  logic signed [DW-1:0] last_out = '0;
  logic prev_rst = 1'b1;

  always @(posedge clk) cycle <= cycle + 1;

  // Output monitor: every out_valid must match the scoreboard head at its due cycle.
  always @(negedge clk) begin
    sb_t e;
    if (out_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_out_valid: out_valid=1 at cycle %0d, required 0", cycle);
      end else begin
        e = sb_q.pop_front();
        if (longint'(out_sample) != longint'(e.data) || cycle != e.due) begin
          errors++;
          $display("[TB] FAIL out_sample: got %0d at cycle %0d, required %0d at cycle %0d",
                   out_sample, cycle, e.data, e.due);
        end
      end
    end else begin
      if (sb_q.size() > 0 && sb_q[0].due < cycle) begin
        e = sb_q.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL missing_out_valid: none by cycle %0d, required at cycle %0d", cycle, e.due);
      end
      if (!rst && !prev_rst) begin
        checks++;
        if (out_sample !== last_out) begin
          errors++;
          $display("[TB] FAIL out_hold: out_sample=%0d without out_valid, required %0d", out_sample, last_out);
        end
      end
    end
    last_out = out_sample;
    prev_rst = rst;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input int s, input int e);
    in_sample = DW'(s);
    in_valid  = 1'b1;
    sb_q.push_back('{data: e, due: cycle + 2});
    tick();
  endtask

  task automatic add_vec(input int g, input int s, input int e);
    vec_t v;
    v.gain = g; v.sample = s; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic hold_btn(input logic up, input logic dn, input int n);
    btn_up = up;
    btn_dn = dn;
    repeat (n) tick();
    btn_up = 1'b0;
    btn_dn = 1'b0;
    repeat (DEB + 5) tick();
  endtask

  task automatic press_up();
    hold_btn(1'b1, 1'b0, DEB + 5);
    if (exp_gain < 15) exp_gain++;
  endtask

  task automatic press_dn();
    hold_btn(1'b0, 1'b1, DEB + 5);
    if (exp_gain > 0) exp_gain--;
  endtask

  // With soft ramp the applied code only moves on sample cycles, so feed silent samples.
  task automatic settle();
`ifdef AUDIO_GAIN_SOFT_RAMP_EN
    for (int i = 0; i < 16; i++) apply_stimulus(0, 0);
    in_valid = 1'b0;
    repeat (3) tick();
`else
    tick();
`endif
  endtask

  task automatic check_gain(input string name);
    settle();
    check_output(name, longint'(gain_code), longint'(exp_gain));
  endtask

  task automatic move_gain(input int g);
    while (exp_gain < g) press_up();
    while (exp_gain > g) press_dn();
    check_gain("gain_move");
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sample = '0; btn_up = 1'b0; btn_dn = 1'b0;
    exp_gain = 8;

    add_vec(8, 1000, 1000);
    add_vec(8, -1000, -1000);
    add_vec(8, 8388607, 8388607);
    add_vec(8, -8388608, -8388608);
    add_vec(15, 8388607, 8388607);
    add_vec(15, -8388608, -8388608);
    add_vec(15, 1000, 1875);
    add_vec(15, -1000, -1875);
    add_vec(15, 7, 13);
    add_vec(15, -7, -14);
    add_vec(15, 4473924, 8388607);
    add_vec(15, 4473925, 8388607);
    add_vec(15, -4473924, -8388608);
    add_vec(15, -4473925, -8388608);
    add_vec(12, 1000, 1500);
    add_vec(12, -3, -5);
    add_vec(12, 100, 150);
    add_vec(3, 1000, 375);
    add_vec(3, -1000, -375);
    add_vec(3, 5, 1);
    add_vec(0, 8388607, 0);
    add_vec(0, -8388608, 0);

    repeat (3) tick();
    check_output("reset_out_valid", longint'(out_valid), 0);
    check_output("reset_out_sample", longint'(out_sample), 0);
    check_output("reset_gain_code", longint'(gain_code), 8);
    rst = 1'b0;
    tick();

    // Debounce window: one cycle short is a glitch, exactly the window is a press.
    hold_btn(1'b1, 1'b0, DEB - 1);
    check_gain("glitch_short");
    hold_btn(1'b1, 1'b0, DEB);
    exp_gain = 9;
    check_gain("press_exact_window");
    press_dn();
    check_gain("press_down");
    press_up();
    check_gain("press_long");
    press_dn();
    hold_btn(1'b1, 1'b1, DEB + 5);
    check_gain("simultaneous_press");

    // Runs of equal gain are issued back to back.
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].gain != exp_gain) begin
        in_valid = 1'b0;
        repeat (3) tick();
        move_gain(vecs[i].gain);
      end
      apply_stimulus(vecs[i].sample, vecs[i].exp);
    end
    in_valid = 1'b0;
    repeat (4) tick();

    press_dn();
    check_gain("saturate_low");
    move_gain(8);
    for (int i = 0; i < 10; i++) press_up();
    check_gain("saturate_high");

    apply_stimulus(1000, 1875);
    in_valid = 1'b0;
    repeat (4) tick();
    apply_stimulus(500, 937);
    in_valid = 1'b0;
    rst = 1'b1;
    sb_q.delete();
    exp_gain = 8;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check_output("rst_flight_out_valid", longint'(out_valid), 0);
    check_output("rst_flight_out_sample", longint'(out_sample), 0);
    check_output("rst_flight_gain_code", longint'(gain_code), 8);
    repeat (4) tick();

    for (int i = 0; i < 8; i++) press_dn();
`ifdef AUDIO_GAIN_SOFT_RAMP_EN
    check_output("ramp_gain_before", longint'(gain_code), 8);
    for (int i = 0; i < 10; i++) apply_stimulus(800, (i < 8) ? 100 * (8 - i) : 0);
`else
    check_output("ramp_gain_before", longint'(gain_code), 0);
    for (int i = 0; i < 10; i++) apply_stimulus(800, 0);
`endif
    in_valid = 1'b0;
    repeat (3) tick();
    check_output("ramp_gain_after", longint'(gain_code), 0);

    repeat (5) tick();
    check_output("scoreboard_drained", longint'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_gain.md
AUDIO_GAIN -- requirements
Module: audio_gain

Interface
REQ-001 Parameter DW, default 24: signed sample width, in and out.
REQ-002 Parameter DEBOUNCE_CYCLES, default 250000: consecutive stable cycles needed to accept a button level.
REQ-003 Parameter RESET_GAIN, default 8: gain code loaded at reset (8 = unity).
REQ-004 Port clk  input  1: single clock; all logic on posedge clk.
REQ-005 Port rst  input  1: reset, synchronous, active-high.
REQ-006 Port in_valid  input  1: one-cycle strobe marking in_sample valid (DDS valid).
REQ-007 Port in_sample  input  DW: signed input sample.
REQ-008 Port btn_up  input  1: raw asynchronous volume-up button, active-high.
REQ-009 Port btn_dn  input  1: raw asynchronous volume-down button, active-high.
REQ-010 Port out_valid  output  1: one-cycle strobe marking out_sample valid.
REQ-011 Port out_sample  output  DW: signed scaled sample, held until the next out_valid.
REQ-012 Port gain_code  output  4: current applied gain code, 0..15.

Function
REQ-013 btn_up and btn_dn SHALL each pass through a 2-flop synchronizer before debounce.
REQ-014 Debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any reversal restarts the count.
REQ-015 Rising edge of debounced up SHALL increment target code, saturating at 15; rising edge of debounced down SHALL decrement, saturating at 0.
REQ-016 Up and down rising edges in the same cycle SHALL leave target unchanged.
REQ-017 Gain factor SHALL be gain_code/8 (unsigned Q1.3): code 0 = mute, 8 = unity, 15 = 1.875.
REQ-018 Output SHALL be (in_sample * gain_code) arithmetically shifted right 3, saturated to [-2^(DW-1), 2^(DW-1)-1].
REQ-019 Multiply SHALL use a full-width DW+5 bit signed product; no intermediate truncation.
REQ-020 Sample SHALL use the gain_code value present in the cycle in_valid is high.
REQ-021 Pipeline SHALL be 2 stages: out_valid asserts exactly 2 cycles after in_valid, one cycle wide.
REQ-022 Back-to-back in_valid on consecutive cycles SHALL produce back-to-back out_valid with no drop.
REQ-023 in_sample SHALL be ignored when in_valid is low; out_sample SHALL not change without out_valid.

Reset
REQ-024 On rst: out_valid = 0, out_sample = 0, gain_code = RESET_GAIN, target = RESET_GAIN, pipeline valids cleared.
REQ-025 On rst: synchronizers, debounce counters and debounced levels = 0; a button held through reset SHALL register as a press only after DEBOUNCE_CYCLES cycles post-release of rst.
REQ-026 Samples in flight at rst assertion SHALL be discarded; no out_valid during or the cycle after rst.

Configuration
REQ-027 Macro AUDIO_GAIN_SOFT_RAMP_EN defined: gain_code SHALL step 1 toward target on each in_valid cycle (after use per REQ-020), never overshooting.
REQ-028 Macro AUDIO_GAIN_SOFT_RAMP_EN undefined: gain_code SHALL equal target the cycle after target changes; no ramp logic synthesized.

Verification
REQ-029 Reset, gain 8, in_sample 1000 with in_valid -> out_valid 2 cycles later, out_sample 1000.
REQ-030 gain 15, in_sample 0x7FFFFF -> out_sample 0x7FFFFF (saturated); in_sample 0x800000 -> 0x800000.
REQ-031 btn_up glitch high for DEBOUNCE_CYCLES-1 cycles then low -> target unchanged; high for DEBOUNCE_CYCLES+5 -> target 9.
REQ-032 With RAMP_EN, target forced 8->0 by 8 presses, then 10 samples of 800 -> outputs 800,700,...,100,0,0 (code 8..0).
REQ-033 btn_up and btn_dn debounced edges same cycle -> target unchanged; 10 up presses from 8 -> target stops at 15.
REQ-034 rst asserted 1 cycle after in_valid -> no out_valid; outputs per REQ-024 next cycle.
